// File: rtl/exec_pkg.sv
// Shared types for the four-phase execute sequencer: default widths, opcodes and FSM states.
package exec_pkg;

  localparam int DATA_W_DEFAULT = 4;
  localparam int ADDR_W_DEFAULT = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LDI = 3'b101,
    OP_SHL = 3'b110,
    OP_NOP = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  function automatic logic op_writes_rf(input opcode_t op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: one-bit-wider arithmetic so the carry falls out as the top bit.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide  = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        carry = wide[DATA_W];
      end
      OP_SUB: begin
        // carry set means no borrow
        wide  = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        carry = wide[DATA_W];
      end
      OP_AND: wide = {1'b0, a & b};
      OP_OR:  wide = {1'b0, a | b};
      OP_XOR: wide = {1'b0, a ^ b};
      OP_LDI: wide = {1'b0, imm};
      OP_SHL: begin
        wide  = {a, 1'b0};
        carry = wide[DATA_W];
      end
      default: wide = '0;
    endcase
    result = wide[DATA_W-1:0];
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: IDLE -> READ -> EXEC -> WRITE around an external register file.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rf_read_address_1,
  output logic [ADDR_W-1:0] rf_read_address_2,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic              flag_carry,
  output logic              flag_zero,
  output logic              busy
);

  state_t              state_reg, state_next;
  opcode_t             op_reg;
  logic [ADDR_W-1:0]   rd_reg, rs1_reg, rs2_reg;
  logic [ADDR_W-1:0]   read_addr_1_reg, read_addr_2_reg;
  logic [DATA_W-1:0]   imm_reg, opa_reg, opb_reg, result_reg;
  logic                carry_reg, flag_carry_reg, flag_zero_reg;
  logic                accept, write_active;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;

  assign accept = instr_valid && instr_ready;

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_reg),
    .a      (opa_reg),
    .b      (opb_reg),
    .imm    (imm_reg),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_READ;
      ST_READ:  state_next = ST_EXEC;
      ST_EXEC:  state_next = ST_WRITE;
      ST_WRITE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Write strobe is masked by reset so an abort during WRITE never reaches the register file.
  always_comb begin
    instr_ready  = 1'b0;
    busy         = 1'b1;
    write_active = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_WRITE: write_active = op_writes_rf(op_reg) && !reset;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_reg          <= OP_ADD;
      rd_reg          <= '0;
      rs1_reg         <= '0;
      rs2_reg         <= '0;
      imm_reg         <= '0;
      read_addr_1_reg <= '0;
      read_addr_2_reg <= '0;
      opa_reg         <= '0;
      opb_reg         <= '0;
      result_reg      <= '0;
      carry_reg       <= 1'b0;
      flag_carry_reg  <= 1'b0;
      flag_zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept) begin
          op_reg          <= opcode_t'(instr_op);
          rd_reg          <= instr_rd;
          rs1_reg         <= instr_rs1;
          rs2_reg         <= instr_rs2;
          imm_reg         <= instr_imm;
          // read ports move only here, so they are stable through READ and held afterwards
          read_addr_1_reg <= instr_rs1;
          read_addr_2_reg <= instr_rs2;
        end
        ST_READ: begin
          opa_reg <= rf_data_1;
          opb_reg <= rf_data_2;
        end
        ST_EXEC: if (op_writes_rf(op_reg)) begin
          result_reg <= alu_result;
          carry_reg  <= alu_carry;
        end
        ST_WRITE: if (op_writes_rf(op_reg)) begin
          flag_carry_reg <= carry_reg;
          flag_zero_reg  <= (result_reg == '0);
        end
        default: ;
      endcase
    end
  end

  assign rf_read_address_1 = read_addr_1_reg;
  assign rf_read_address_2 = read_addr_2_reg;
  assign rf_write_enable   = write_active;
  assign rf_write_address  = rd_reg;
  assign rf_write_data     = result_reg;
  assign result_valid      = write_active;
  assign result_data       = result_reg;
  assign flag_carry        = flag_carry_reg;
  assign flag_zero         = flag_zero_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench: directed scenarios plus random instructions against an arithmetic reference model.
module tb_exec_sequencer;
  localparam int DW = 4;
  localparam int AW = 2;
  localparam int MASK = (1 << DW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic [DW-1:0] instr_imm;
  logic [AW-1:0] rf_read_address_1, rf_read_address_2;
  logic [DW-1:0] rf_data_1, rf_data_2;
  logic          rf_write_enable;
  logic [AW-1:0] rf_write_address;
  logic [DW-1:0] rf_write_data;
  logic          result_valid;
  logic [DW-1:0] result_data;
  logic          flag_carry, flag_zero, busy;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  int model_regs [4];
  int model_c = 0;
  int model_z = 0;

  // environment register file fed only by the DUT write port
  logic [DW-1:0] rf_mem [4];

  always #5 clock = ~clock;

  always @(posedge clock)
    if (rf_write_enable) rf_mem[rf_write_address] <= rf_write_data;

  assign rf_data_1 = rf_mem[rf_read_address_1];
  assign rf_data_2 = rf_mem[rf_read_address_2];

  exec_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock             (clock),
    .reset             (reset),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr_op          (instr_op),
    .instr_rd          (instr_rd),
    .instr_rs1         (instr_rs1),
    .instr_rs2         (instr_rs2),
    .instr_imm         (instr_imm),
    .rf_read_address_1 (rf_read_address_1),
    .rf_read_address_2 (rf_read_address_2),
    .rf_data_1         (rf_data_1),
    .rf_data_2         (rf_data_2),
    .rf_write_enable   (rf_write_enable),
    .rf_write_address  (rf_write_address),
    .rf_write_data     (rf_write_data),
    .result_valid      (result_valid),
    .result_data       (result_data),
    .flag_carry        (flag_carry),
    .flag_zero         (flag_zero),
    .busy              (busy)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Specification-level semantics: plain integer arithmetic, borrow as a comparison.
  function automatic void ref_exec(input int op, input int a, input int b, input int imm,
                                   output int res, output int c);
    res = 0;
    c   = 0;
    case (op)
      0: begin res = (a + b) & MASK; c = (a + b > MASK) ? 1 : 0; end
      1: begin res = (a - b) & MASK; c = (a >= b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = imm & MASK;
      6: begin res = (a * 2) & MASK; c = (a >= (1 << (DW - 1))) ? 1 : 0; end
      default: res = 0;
    endcase
  endfunction

  task automatic scramble_fields();
    logic [31:0] r;
    r = $urandom;
    instr_op  = r[2:0];
    instr_rd  = r[4:3];
    instr_rs1 = r[6:5];
    instr_rs2 = r[8:7];
    instr_imm = r[12:9];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string ctx);
    check_eq({ctx, "_ready"}, int'(instr_ready), 1);
    check_eq({ctx, "_busy"}, int'(busy), 0);
    check_eq({ctx, "_we"}, int'(rf_write_enable), 0);
    check_eq({ctx, "_rv"}, int'(result_valid), 0);
    check_eq({ctx, "_fc"}, int'(flag_carry), 0);
    check_eq({ctx, "_fz"}, int'(flag_zero), 0);
    check_eq({ctx, "_ra1"}, int'(rf_read_address_1), 0);
    check_eq({ctx, "_ra2"}, int'(rf_read_address_2), 0);
    check_eq({ctx, "_wa"}, int'(rf_write_address), 0);
    check_eq({ctx, "_wd"}, int'(rf_write_data), 0);
    check_eq({ctx, "_rd"}, int'(result_data), 0);
  endtask

  // Offers one instruction in IDLE, keeps instr_valid high with junk fields while busy.
  task automatic run_instr(input int op, input int rd, input int rs1, input int rs2, input int imm);
    int exp_res, exp_c, writes;
    ref_exec(op, model_regs[rs1], model_regs[rs2], imm, exp_res, exp_c);
    writes = (op != 7) ? 1 : 0;
    instr_valid = 1'b1;
    instr_op  = op[2:0];
    instr_rd  = rd[AW-1:0];
    instr_rs1 = rs1[AW-1:0];
    instr_rs2 = rs2[AW-1:0];
    instr_imm = imm[DW-1:0];
    check_eq("ready_idle", int'(instr_ready), 1);
    step();
    scramble_fields();
    check_eq("ready_read", int'(instr_ready), 0);
    check_eq("busy_read", int'(busy), 1);
    check_eq("ra1_read", int'(rf_read_address_1), rs1);
    check_eq("ra2_read", int'(rf_read_address_2), rs2);
    check_eq("we_read", int'(rf_write_enable), 0);
    step();
    scramble_fields();
    check_eq("ready_exec", int'(instr_ready), 0);
    check_eq("we_exec", int'(rf_write_enable), 0);
    check_eq("ra1_hold", int'(rf_read_address_1), rs1);
    step();
    scramble_fields();
    check_eq("ready_write", int'(instr_ready), 0);
    check_eq("we_write", int'(rf_write_enable), writes);
    check_eq("rv_write", int'(result_valid), writes);
    if (writes == 1) begin
      check_eq("waddr", int'(rf_write_address), rd);
      check_eq("wdata", int'(rf_write_data), exp_res);
      check_eq("rdata", int'(result_data), exp_res);
    end
    step();
    if (writes == 1) begin
      model_regs[rd] = exp_res;
      model_c = exp_c;
      model_z = (exp_res == 0) ? 1 : 0;
    end
    check_eq("flag_c", int'(flag_carry), model_c);
    check_eq("flag_z", int'(flag_zero), model_z);
    check_eq("busy_idle", int'(busy), 0);
    check_eq("we_idle", int'(rf_write_enable), 0);
    $display("[TB] op=%0d rd=%0d rs1=%0d rs2=%0d imm=%0h -> res=%0h c=%0d z=%0d",
             op, rd, rs1, rs2, imm, exp_res, model_c, model_z);
  endtask

  // Starts an LDI that would change R3, then resets in the given phase (1=READ,2=EXEC,3=WRITE).
  task automatic reset_abort(input int phase);
    int imm;
    imm = (~model_regs[3]) & MASK;
    instr_valid = 1'b1;
    instr_op  = 3'b101;
    instr_rd  = 2'd3;
    instr_rs1 = 2'd1;
    instr_rs2 = 2'd2;
    instr_imm = imm[DW-1:0];
    step();
    for (int k = 1; k < phase; k++) step();
    reset = 1'b1;
    #1;
    check_eq("abort_we", int'(rf_write_enable), 0);
    check_eq("abort_rv", int'(result_valid), 0);
    step();
    reset = 1'b0;
    instr_valid = 1'b0;
    model_c = 0;
    model_z = 0;
    check_reset_outputs($sformatf("abort%0d", phase));
    check_eq("abort_r3", int'(rf_mem[3]), model_regs[3]);
    $display("[TB] reset abort in phase %0d", phase);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) model_regs[i] = 0;
    reset = 1'b1;
    instr_valid = 1'b1;
    scramble_fields();
    step();
    step();
    step();
    // reset must win over a valid offered in the same cycles
    check_reset_outputs("reset");
    reset = 1'b0;
    instr_valid = 1'b0;
    step();
    check_eq("idle_after_reset", int'(busy), 0);

    for (int i = 0; i < 4; i++) run_instr(5, i, 0, 0, i + 1);

    run_instr(5, 1, 0, 0, 7);
    run_instr(5, 2, 0, 0, 9);
    run_instr(0, 0, 1, 2, 0);
    check_eq("add_zero", int'(flag_zero), 1);
    check_eq("add_carry", int'(flag_carry), 1);

    run_instr(5, 1, 0, 0, 3);
    run_instr(5, 2, 0, 0, 5);
    run_instr(1, 3, 1, 2, 0);
    run_instr(1, 0, 2, 1, 0);

    run_instr(5, 1, 0, 0, 10);
    run_instr(0, 2, 1, 1, 0);
    check_eq("raw_r2", int'(rf_mem[2]), 4);

    run_instr(7, 0, 1, 2, 3);
    run_instr(6, 3, 1, 0, 0);

    reset_abort(1);
    reset_abort(2);
    reset_abort(3);

    for (int n = 0; n < 40; n++)
      run_instr(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(MASK, 0)));

    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) check_eq($sformatf("final_r%0d", i), int'(rf_mem[i]), model_regs[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
